controle_posse24: RTL and testbench
===================================

# controle_posse24

Control stage directly upstream of the 24-second countdown of the basketball scoreboard. Turns three raw push-buttons (pause/run, 24 s reset, possession change) into the countdown's control inputs: a 1 Hz square-wave clock, a stop level and a reset request. The reset request is held until the countdown reports 24 back. Also freezes the clock when the countdown reaches zero (shot-clock violation).

## Interface
- CLK_FREQ_HZ, 50000000, board clock frequency
- TICK_HZ, 1, countdown clock frequency; HALF = CLK_FREQ_HZ/(2*TICK_HZ), integer, ≥2
- DEBOUNCE_CYCLES, 1000000, stable-level cycles required to accept a button change (used only with DEBOUNCE_EN)
- clock_in  input  1  board clock, rising edge
- nReset  input  1  reset, asynchronous, active-low
- botaoPausa  input  1  raw button, active-high, asynchronous: toggle run/stop
- botaoReset24  input  1  raw button, active-high, asynchronous: reload 24
- botaoPosse  input  1  raw button, active-high, asynchronous: possession change
- contagem  input  5  current countdown value fed back from the countdown stage
- clockSegundo  output  1  square wave to countdown clock; countdown acts on its falling edge
- chaveParar  output  1  1 = countdown frozen
- reset24  output  1  reload request to countdown, level

## Operation
- Each button: 2-flop synchronizer, then conditioner (see Configuration), then rising-edge detector → one-cycle events evPausa, evReset, evPosse.
- Divider: counter 0..HALF-1, runs when divEn = (estado==CORRENDO) || reset24. On wrap, toggle clockSegundo. When divEn=0, counter and clockSegundo hold.
- FSM states: PARADO, CORRENDO, ESTOURO. chaveParar = (estado != CORRENDO).
  - PARADO + evPausa → CORRENDO.
  - CORRENDO + evPausa → PARADO.
  - CORRENDO + contagem==0 + !reset24 → ESTOURO.
  - ESTOURO: evPausa ignored. evReset or evPosse → PARADO.
- Reload handshake:
  - evReset or evPosse in any state with contagem != 24 → reset24=1.
  - reset24 clears on the first clock_in cycle where contagem==24.
  - If contagem==24 already, no assertion.
  - While reset24=1, the divider runs even in PARADO/ESTOURO, so the countdown gets a falling edge.
  - Repeat events while pending are absorbed.
- evPosse does not change run state, except that it leaves ESTOURO (to PARADO).
- Simultaneous events in one cycle: the reload request and the pausa toggle both take effect. In ESTOURO, evReset/evPosse win and evPausa is dropped.

## Timing
- Reset values: clockSegundo=1, chaveParar=1, reset24=0, estado=PARADO, divider=0, synchronizer/debounce state=0.
- nReset asserted mid-operation: immediate return to reset values, any pending reload dropped.
- Button-to-event latency:
  - with DEBOUNCE_EN: 2 + DEBOUNCE_CYCLES + 1 cycles;
  - without: 3 cycles.
- FSM and reset24 register one cycle after the event.
- From entering CORRENDO at a fresh divider (count 0, clockSegundo=1): first falling edge after HALF cycles, then every 2*HALF cycles.
- Reload completes within ≤ 2*HALF + 2 cycles of reset24 rising.
- contagem is sampled synchronously on clock_in. The countdown updates on a clockSegundo falling edge, which is clock_in-derived, so no synchronizer is needed.

## Configuration
- DEBOUNCE_EN defined: per-button counter.
  - The accepted level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - The counter clears on any return to the accepted level.
- DEBOUNCE_EN undefined: the synchronized input is the accepted level. DEBOUNCE_CYCLES is unused and no counter is synthesized.

## Test plan
Parameters CLK_FREQ_HZ=20, TICK_HZ=1 (HALF=10), DEBOUNCE_CYCLES=4; countdown model attached.
- After reset, no buttons for 100 cycles: chaveParar=1, reset24=0, clockSegundo stays 1, contagem stays 24.
- Pausa press (DEBOUNCE_EN):
  - chaveParar falls exactly 8 cycles after the input rises;
  - clockSegundo falls 10 cycles later;
  - contagem becomes 23 at that edge.
- Pausa input with a 3-cycle glitch (DEBOUNCE_EN): no event, chaveParar stays 1. Same glitch without DEBOUNCE_EN: toggles to run.
- Run until contagem==0: ESTOURO entered, chaveParar=1, clockSegundo frozen.
  - Pausa press: no change.
  - Reset24 press: reset24=1 and the divider runs; contagem returns to 24 within 22 cycles; reset24 falls next cycle; chaveParar stays 1.
- While running at contagem=15, press pausa and posse in the same cycle: chaveParar=1, reset24 handshake completes, contagem=24, state PARADO.
- nReset pulsed low while reset24=1 and running: all outputs return to reset values immediately, with no further clockSegundo edges.

Source files
------------

// File: rtl/controle_posse24.sv
// controle_posse24: shot-clock control stage. Conditions three buttons into run/stop, reload
// and possession events, and drives the 24 s countdown's clock, stop level and reload request.
// Optional build macro DEBOUNCE_EN adds a per-button stability counter of DEBOUNCE_CYCLES.

module controle_posse24_botao #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock_in,
    input  logic nReset,
    input  logic i_botao,
    output logic o_evento
);

    logic r_sync1;
    logic r_sync2;
    logic r_aceito_d;
    logic r_evento;
    logic w_aceito;

    always_ff @(posedge clock_in or negedge nReset) begin
        if (!nReset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_botao;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_aceito;

    // The accepted level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock_in or negedge nReset) begin
        if (!nReset) begin
            r_cnt    <= '0;
            r_aceito <= 1'b0;
        end else if (r_sync2 == r_aceito) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_aceito <= r_sync2;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_aceito = r_aceito;
`else
    assign w_aceito = r_sync2;
`endif

    always_ff @(posedge clock_in or negedge nReset) begin
        if (!nReset) begin
            r_aceito_d <= 1'b0;
            r_evento   <= 1'b0;
        end else begin
            r_aceito_d <= w_aceito;
            r_evento   <= w_aceito & ~r_aceito_d;
        end
    end

    assign o_evento = r_evento;

endmodule

module controle_posse24 #(
    parameter int CLK_FREQ_HZ     = 50000000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clock_in,
    input  logic       nReset,
    input  logic       botaoPausa,
    input  logic       botaoReset24,
    input  logic       botaoPosse,
    input  logic [4:0] contagem,
    output logic       clockSegundo,
    output logic       chaveParar,
    output logic       reset24,
    output logic [1:0] o_estado
);

    localparam int HALF  = CLK_FREQ_HZ / (2 * TICK_HZ);
    localparam int DIV_W = $clog2(HALF);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        CORRENDO = 2'd1,
        ESTOURO  = 2'd2
    } estado_t;

    estado_t          r_estado;
    logic             r_chave;
    logic             r_reset24;
    logic [DIV_W-1:0] r_div;
    logic             r_clk;

    logic w_ev_pausa;
    logic w_ev_reset;
    logic w_ev_posse;
    logic w_recarga;
    logic w_div_en;

    controle_posse24_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pausa (
        .clock_in (clock_in),
        .nReset   (nReset),
        .i_botao  (botaoPausa),
        .o_evento (w_ev_pausa)
    );

    controle_posse24_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset (
        .clock_in (clock_in),
        .nReset   (nReset),
        .i_botao  (botaoReset24),
        .o_evento (w_ev_reset)
    );

    controle_posse24_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_posse (
        .clock_in (clock_in),
        .nReset   (nReset),
        .i_botao  (botaoPosse),
        .o_evento (w_ev_posse)
    );

    assign w_recarga = w_ev_reset | w_ev_posse;
    // A pending reload keeps the divider alive so the countdown sees a falling edge.
    assign w_div_en  = (r_estado == CORRENDO) || r_reset24;

    always_ff @(posedge clock_in or negedge nReset) begin
        if (!nReset) begin
            r_div <= '0;
            r_clk <= 1'b1;
        end else if (w_div_en) begin
            if (r_div == DIV_W'(HALF - 1)) begin
                r_div <= '0;
                r_clk <= ~r_clk;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or negedge nReset) begin
        if (!nReset) begin
            r_estado  <= PARADO;
            r_chave   <= 1'b1;
            r_reset24 <= 1'b0;
        end else begin
            if (r_reset24) begin
                if (contagem == 5'd24) r_reset24 <= 1'b0;
            end else if (w_recarga && (contagem != 5'd24)) begin
                r_reset24 <= 1'b1;
            end

            case (r_estado)
                PARADO: begin
                    if (w_ev_pausa) begin
                        r_estado <= CORRENDO;
                        r_chave  <= 1'b0;
                    end
                end
                CORRENDO: begin
                    if (w_ev_pausa) begin
                        r_estado <= PARADO;
                        r_chave  <= 1'b1;
                    end else if ((contagem == 5'd0) && !r_reset24) begin
                        r_estado <= ESTOURO;
                        r_chave  <= 1'b1;
                    end
                end
                ESTOURO: begin
                    // Pause is ignored here; only a reload or possession change releases it.
                    if (w_recarga) begin
                        r_estado <= PARADO;
                        r_chave  <= 1'b1;
                    end
                end
                default: begin
                    r_estado <= PARADO;
                    r_chave  <= 1'b1;
                end
            endcase
        end
    end

    assign clockSegundo = r_clk;
    assign chaveParar   = r_chave;
    assign reset24      = r_reset24;
    assign o_estado     = r_estado;

endmodule

// File: tb/tb_controle_posse24.sv
// Bench for controle_posse24 with a behavioural 24 s countdown attached to its outputs.
// Works in both builds; DEBOUNCE_EN selects the expected event latency and glitch behaviour.

module tb_controle_posse24;

  localparam int CLK_FREQ_HZ     = 20;
  localparam int TICK_HZ         = 1;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int HALF            = 10;
`ifdef DEBOUNCE_EN
  localparam int EV_LAT = 2 + DEBOUNCE_CYCLES + 1;
  localparam logic GLITCH_STOP = 1'b1;
`else
  localparam int EV_LAT = 3;
  localparam logic GLITCH_STOP = 1'b0;
`endif

  logic       clock_in = 1'b0;
  logic       nReset;
  logic       botaoPausa;
  logic       botaoReset24;
  logic       botaoPosse;
  logic [4:0] contagem = 5'd24;
  logic       clockSegundo;
  logic       chaveParar;
  logic       reset24;
  logic [1:0] o_estado;

  int n_tests = 0;
  int n_fail  = 0;
  int cs_falls = 0;
  logic [31:0] exp_q[$];

  controle_posse24 #(
    .CLK_FREQ_HZ     (CLK_FREQ_HZ),
    .TICK_HZ         (TICK_HZ),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clock_in     (clock_in),
    .nReset       (nReset),
    .botaoPausa   (botaoPausa),
    .botaoReset24 (botaoReset24),
    .botaoPosse   (botaoPosse),
    .contagem     (contagem),
    .clockSegundo (clockSegundo),
    .chaveParar   (chaveParar),
    .reset24      (reset24),
    .o_estado     (o_estado)
  );

  // clock / reset block
  always #5 clock_in = ~clock_in;

  // countdown model: acts on the falling edge of clockSegundo
  always @(negedge clockSegundo) begin
    cs_falls = cs_falls + 1;
    if (reset24) contagem <= 5'd24;
    else if (!chaveParar && contagem != 5'd0) contagem <= contagem - 5'd1;
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: observed %0d expected <queue empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic wait_cont(input logic [4:0] v, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= max_cycles; i++) begin
      if (contagem == v) begin
        ok = 1'b1;
        break;
      end
      if (i < max_cycles) step(1);
    end
  endtask

  initial begin
    bit ok;
    int f0;
    botaoPausa   = 1'b0;
    botaoReset24 = 1'b0;
    botaoPosse   = 1'b0;
    nReset       = 1'b1;
    #1 nReset    = 1'b0;
    step(3);
    nReset = 1'b1;

    // reset state and idle
    check("rst_chave", chaveParar, 1);
    check("rst_reset24", reset24, 0);
    check("rst_clk", clockSegundo, 1);
    check("rst_estado", o_estado, 0);
    f0 = cs_falls;
    step(100);
    check("idle_falls", cs_falls - f0, 0);
    check("idle_clk", clockSegundo, 1);
    check("idle_chave", chaveParar, 1);
    check("idle_reset24", reset24, 0);
    check("idle_contagem", contagem, 24);

    // 3-cycle glitch on pausa
    botaoPausa = 1'b1;
    exp_q.push_back(GLITCH_STOP);
    step(3);
    botaoPausa = 1'b0;
    step(5);
    check_sb("glitch_chave", chaveParar);

    // back to a fresh divider
    nReset = 1'b0;
    step(2);
    nReset = 1'b1;
    step(1);
    check("rst2_chave", chaveParar, 1);
    check("rst2_clk", clockSegundo, 1);
    check("rst2_estado", o_estado, 0);

    // pausa press: exact latency, then first falling edge after HALF cycles
    botaoPausa = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(0);
    step(EV_LAT);
    check_sb("pausa_pre", chaveParar);
    step(1);
    check_sb("pausa_run", chaveParar);
    botaoPausa = 1'b0;
    step(HALF - 1);
    check("clk_before_fall", clockSegundo, 1);
    step(1);
    check("clk_first_fall", clockSegundo, 0);
    check("contagem_23", contagem, 23);

    // run to zero: shot-clock violation
    wait_cont(5'd0, 23 * 2 * HALF + 10, ok);
    check("reach_zero", ok, 1);
    step(2);
    check("estouro_estado", o_estado, 2);
    check("estouro_chave", chaveParar, 1);
    check("estouro_clk", clockSegundo, 0);
    f0 = cs_falls;
    step(30);
    check("estouro_frozen", cs_falls - f0, 0);
    check("estouro_contagem", contagem, 0);

    // pausa is ignored in ESTOURO
    botaoPausa = 1'b1;
    step(EV_LAT + 1);
    botaoPausa = 1'b0;
    step(10);
    check("estouro_pausa_estado", o_estado, 2);
    check("estouro_pausa_chave", chaveParar, 1);
    check("estouro_pausa_r24", reset24, 0);

    // reset24 press leaves ESTOURO and reloads
    botaoReset24 = 1'b1;
    exp_q.push_back(1);
    step(EV_LAT + 1);
    check_sb("r24_rise", reset24);
    check("r24_estado", o_estado, 0);
    botaoReset24 = 1'b0;
    wait_cont(5'd24, 2 * HALF + 2, ok);
    check("r24_reload", ok, 1);
    check("r24_hold", reset24, 1);
    step(1);
    check("r24_clear", reset24, 0);
    check("r24_chave", chaveParar, 1);

    // simultaneous pausa + posse while running at 15
    botaoPausa = 1'b1;
    step(EV_LAT + 1);
    botaoPausa = 1'b0;
    check("run2_chave", chaveParar, 0);
    wait_cont(5'd15, 9 * 2 * HALF + 3 * HALF, ok);
    check("reach_15", ok, 1);
    botaoPausa = 1'b1;
    botaoPosse = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(1);
    step(EV_LAT + 1);
    check_sb("dual_chave", chaveParar);
    check_sb("dual_r24", reset24);
    botaoPausa = 1'b0;
    botaoPosse = 1'b0;
    wait_cont(5'd24, 2 * HALF + 2, ok);
    check("dual_reload", ok, 1);
    step(1);
    check("dual_r24_clear", reset24, 0);
    check("dual_estado", o_estado, 0);
    check("dual_contagem", contagem, 24);
    check("dual_chave_end", chaveParar, 1);

    // nReset while running with a reload pending
    botaoPausa = 1'b1;
    step(EV_LAT + 1);
    botaoPausa = 1'b0;
    wait_cont(5'd22, 3 * 2 * HALF + 10, ok);
    check("reach_22", ok, 1);
    botaoReset24 = 1'b1;
    step(EV_LAT + 1);
    botaoReset24 = 1'b0;
    check("pre_rst_r24", reset24, 1);
    check("pre_rst_chave", chaveParar, 0);
    nReset = 1'b0;
    #1;
    check("async_clk", clockSegundo, 1);
    check("async_chave", chaveParar, 1);
    check("async_r24", reset24, 0);
    check("async_estado", o_estado, 0);
    f0 = cs_falls;
    step(3);
    nReset = 1'b1;
    step(40);
    check("post_rst_falls", cs_falls - f0, 0);
    check("post_rst_r24", reset24, 0);
    check("post_rst_chave", chaveParar, 1);
    check("post_rst_clk", clockSegundo, 1);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
